// File: rtl/fpu_mul_pkg.sv
// Shared constants and the normalised-stage record for the FP32 multiplier
// back end (normalise -> round -> pack).
package fpu_mul_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  localparam int FP_FRAC_W  = 23;
  localparam int NORM_EXP_W = 10;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic                          sign;
    logic signed [NORM_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0]          frac;
    logic                          rnd;
    logic                          nan;
    logic                          inf;
    logic                          zero;
  } norm_s;

  function automatic logic [31:0] fp_pack(input logic sign,
                                          input logic [7:0] exp,
                                          input logic [FP_FRAC_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// Second-stage combinational logic: applies the round-up increment, then
// resolves specials and exponent range before packing an FP32 word.
module fpu_round_pack
  import fpu_mul_pkg::*;
(
  input  norm_s       i_norm,
  output logic [31:0] o_data,
  output logic        o_ovf,
  output logic        o_udf
);

  localparam int EW = NORM_EXP_W + 2;

  logic [FP_FRAC_W:0]     sum;
  logic                   carry;
  logic [FP_FRAC_W-1:0]   frac_r;
  logic signed [EW-1:0]   exp_w;

  // Round, renormalise on carry, then pick the result by priority.
  always_comb begin
    sum    = {1'b0, i_norm.frac} + {{FP_FRAC_W{1'b0}}, i_norm.rnd};
    carry  = sum[FP_FRAC_W];
    frac_r = carry ? {FP_FRAC_W{1'b0}} : sum[FP_FRAC_W-1:0];
    // Two guard bits so the +1 from a carry cannot wrap the signed exponent.
    exp_w  = $signed({{2{i_norm.exp[NORM_EXP_W-1]}}, i_norm.exp})
           + $signed({{(EW-1){1'b0}}, carry});
    o_ovf  = 1'b0;
    o_udf  = 1'b0;
    if (i_norm.nan) begin
      o_data = FP_QNAN;
    end else if (i_norm.inf) begin
      o_data = fp_pack(i_norm.sign, 8'hFF, {FP_FRAC_W{1'b0}});
    end else if (i_norm.zero) begin
      o_data = fp_pack(i_norm.sign, 8'h00, {FP_FRAC_W{1'b0}});
    end else if (exp_w >= $signed(EW'(FP_EXP_MAX))) begin
      o_data = fp_pack(i_norm.sign, 8'hFF, {FP_FRAC_W{1'b0}});
      o_ovf  = 1'b1;
    end else if (exp_w <= $signed({EW{1'b0}})) begin
      o_data = fp_pack(i_norm.sign, 8'h00, {FP_FRAC_W{1'b0}});
      o_udf  = 1'b1;
    end else begin
      o_data = fp_pack(i_norm.sign, exp_w[7:0], frac_r);
    end
  end

endmodule

// File: rtl/fpu_mul_norm_round.sv
// FP32 multiplier back end: two-stage valid/ready pipeline that normalises the
// truncated mantissa product, then rounds, range-checks and packs the result.
module fpu_mul_norm_round
  import fpu_mul_pkg::*;
#(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_EXP  = NORM_EXP_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sign,
  input  logic [SIZE_EXP-1:0] i_exp_sum,
  input  logic [SIZE_DATA-1:0] i_man,
  input  logic                i_over_flag,
  input  logic                i_rounding,
  input  logic                i_is_nan,
  input  logic                i_is_inf,
  input  logic                i_is_zero,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_data,
  output logic                o_ovf,
  output logic                o_udf
);

  logic        s1_valid_q, s1_valid_d;
  norm_s       s1_q, s1_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] data_q, data_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  logic        in_fire, out_fire, s2_load;
  logic [31:0] rp_data;
  logic        rp_ovf, rp_udf;

  // S1 can always make room when S2 is empty or draining this cycle.
  assign o_ready  = ~s1_valid_q | ~s2_valid_q | i_ready;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = s2_valid_q & i_ready;
  assign s2_load  = s1_valid_q & (~s2_valid_q | i_ready);

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_d.sign  = i_sign;
      s1_d.rnd   = i_rounding;
      s1_d.nan   = i_is_nan;
      s1_d.inf   = i_is_inf;
      s1_d.zero  = i_is_zero;
      if (i_over_flag) begin
        s1_d.frac = i_man[SIZE_DATA-1:1];
        s1_d.exp  = $signed(i_exp_sum) + $signed({{(SIZE_EXP-1){1'b0}}, 1'b1});
      end else begin
        s1_d.frac = i_man[SIZE_DATA-2:0];
        s1_d.exp  = $signed(i_exp_sum);
      end
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  fpu_round_pack u_round_pack (
    .i_norm (s1_q),
    .o_data (rp_data),
    .o_ovf  (rp_ovf),
    .o_udf  (rp_udf)
  );

  // Flags are cleared whenever the output slot empties; data is simply held.
  always_comb begin
    s2_valid_d = s2_valid_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      data_d     = rp_data;
      ovf_d      = rp_ovf;
      udf_d      = rp_udf;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      data_q     <= 32'h0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign o_valid = s2_valid_q;
  assign o_data  = data_q;
  assign o_ovf   = ovf_q;
  assign o_udf   = udf_q;

endmodule

// File: tb/tb_fpu_mul_norm_round.sv
// Scoreboard bench for fpu_mul_norm_round: expected results are queued when a
// beat is driven and compared in order as the pipeline emits them.
module tb_fpu_mul_norm_round;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp_sum;
    logic [23:0] man;
    logic        over;
    logic        rnd;
    logic        nan;
    logic        inf;
    logic        zero;
  } beat_t;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, o_ready, i_sign;
  logic [9:0]  i_exp_sum;
  logic [23:0] i_man;
  logic        i_over_flag, i_rounding, i_is_nan, i_is_inf, i_is_zero;
  logic        o_valid, i_ready;
  logic [31:0] o_data;
  logic        o_ovf, o_udf;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_exp;
  logic        stall_seen = 1'b0;
  logic [31:0] stall_data = 32'h0;
  logic        saw_ready_low = 1'b0;

  fpu_mul_norm_round dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp_sum(i_exp_sum), .i_man(i_man),
    .i_over_flag(i_over_flag), .i_rounding(i_rounding),
    .i_is_nan(i_is_nan), .i_is_inf(i_is_inf), .i_is_zero(i_is_zero),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_ovf(o_ovf), .o_udf(o_udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Value-level model: scale the 24-bit significand, renormalise, then classify.
  function automatic logic [33:0] model(input beat_t b);
    int          e;
    logic [24:0] m;
    logic [22:0] f;
    logic [31:0] d;
    logic        ov, ud;
    ov = 1'b0;
    ud = 1'b0;
    e  = $signed(b.exp_sum) + (b.over ? 1 : 0);
    f  = b.over ? b.man[23:1] : b.man[22:0];
    m  = {2'b01, f} + {24'd0, b.rnd};
    if (m >= 25'h100_0000) begin
      m = m >> 1;
      e = e + 1;
    end
    if (b.nan)           d = 32'h7FC0_0000;
    else if (b.inf)      d = {b.sign, 8'hFF, 23'd0};
    else if (b.zero)     d = {b.sign, 31'd0};
    else if (e >= 255) begin d = {b.sign, 8'hFF, 23'd0}; ov = 1'b1; end
    else if (e <= 0)   begin d = {b.sign, 31'd0};        ud = 1'b1; end
    else                 d = {b.sign, 8'(e), m[22:0]};
    return {ov, ud, d};
  endfunction

  function automatic beat_t mk(input logic s, input int e, input logic [23:0] man,
                               input logic over, input logic rnd,
                               input logic nan, input logic inf, input logic zero);
    beat_t b;
    b.sign = s; b.exp_sum = 10'(e); b.man = man; b.over = over;
    b.rnd = rnd; b.nan = nan; b.inf = inf; b.zero = zero;
    return b;
  endfunction

  task automatic send(input beat_t b);
    int n = 0;
    i_valid = 1'b1; i_sign = b.sign; i_exp_sum = b.exp_sum; i_man = b.man;
    i_over_flag = b.over; i_rounding = b.rnd;
    i_is_nan = b.nan; i_is_inf = b.inf; i_is_zero = b.zero;
    exp_q.push_back(model(b));
    @(negedge clk);
    while (!o_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("send_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    int    sel;
    b = mk($urandom_range(0, 1), int'($urandom_range(0, 300)) - 20,
           24'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
           1'b0, 1'b0, 1'b0);
    sel = $urandom_range(0, 15);
    if (sel == 0) b.nan = 1'b1;
    else if (sel == 1) b.inf = 1'b1;
    else if (sel == 2) b.zero = 1'b1;
    else b.nan = 1'b0;
    return b;
  endfunction

  // Output monitor: compare on each transfer, watch stalls and idle flags.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {o_ovf, o_udf, o_data}, 64'h0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", {30'd0, o_ovf, o_udf, o_data}, {30'd0, mon_exp});
        end
      end
      if (!o_valid) check("idle_flags", {o_ovf, o_udf}, 64'd0);
      if (o_valid && !i_ready) begin
        if (stall_seen) check("stall_hold", o_data, stall_data);
        stall_seen = 1'b1;
        stall_data = o_data;
      end else begin
        stall_seen = 1'b0;
      end
      if (!o_ready) saw_ready_low = 1'b1;
    end
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_sign = 1'b0;
    i_exp_sum = 10'd0; i_man = 24'd0; i_over_flag = 1'b0; i_rounding = 1'b0;
    i_is_nan = 1'b0; i_is_inf = 1'b0; i_is_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 64'd0);
    check("rst_data", o_data, 64'd0);
    check("rst_flags", {o_ovf, o_udf}, 64'd0);
    i_rst = 1'b0;
    #1;
    check("rst_ready", o_ready, 64'd1);

    // 1.5*1.5: product bits [46:23] = 0x200000 with bit 47 set; two-cycle latency.
    send(mk(1'b0, 127, 24'h200000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    i_valid = 1'b0;
    check("lat_s1", o_valid, 64'd0);
    @(posedge clk); #1;
    check("lat_s2", o_valid, 64'd1);
    check("lat_data", o_data, 64'h4010_0000);
    wait_drain();

    // Rounding carry and exponent range boundaries.
    send(mk(1'b0, 127, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    send(mk(1'b0, 254, 24'h800000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    send(mk(1'b0,   0, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(mk(1'b1,  -5, 24'h923456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(mk(1'b0, 254, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    send(mk(1'b1,   0, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    send(mk(1'b0, 253, 24'h7FFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    send(mk(1'b0,   1, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // Specials, including priority of NaN over inf/zero.
    send(mk(1'b1, 127, 24'h123456, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    send(mk(1'b0, 400, 24'h123456, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    send(mk(1'b1, 127, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    send(mk(1'b1, -30, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    send(mk(1'b0, 300, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    i_valid = 1'b0;
    wait_drain();

    // Backpressure: 8 back-to-back beats with a 3-cycle consumer stall.
    saw_ready_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(mk(i[0], 100 + i, 24'h800000 + 24'(i * 4099), i[1], i[2], 1'b0, 1'b0, 1'b0));
        i_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    wait_drain();
    check("ready_dropped", saw_ready_low, 64'd1);

    // Random stream with random consumer readiness.
    fork
      begin
        for (int i = 0; i < 30; i++) send(rand_beat());
        i_valid = 1'b0;
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1 i_ready = 1'($urandom_range(0, 1));
        end
        i_ready = 1'b1;
      end
    join
    i_ready = 1'b1;
    wait_drain();

    // Reset with both stages occupied drops the beats.
    i_ready = 1'b0;
    send(mk(1'b0, 130, 24'h812345, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(mk(1'b1, 131, 24'h834567, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    i_valid = 1'b0;
    check("full_ready", o_ready, 64'd0);
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", o_valid, 64'd0);
    check("mid_rst_data", o_data, 64'd0);
    check("mid_rst_flags", {o_ovf, o_udf}, 64'd0);
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale", o_valid, 64'd0);
    end
    @(posedge clk); #1;
    send(mk(1'b0, 127, 24'h400000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    i_valid = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
